// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the MEM stage: a word-addressed array behind an
// IDLE/BUSY/DONE handshake that freezes the pipeline for LATENCY+1 cycles per access.
module data_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Memory_read_i,
    input  logic        Memory_write_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [15:0] access_cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    is_wr_q, is_wr_d;
    logic                    misal_q, misal_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [15:0]             acc_q, acc_d;
    logic                    stall;
    logic                    mem_we;

    logic [31:0]             mem_q [DEPTH];

    // Upper address bits alias into the array by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^address_i[31:DEPTH_LOG2+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        misal_d = misal_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        acc_d   = acc_q;
        stall   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Memory_read_i || Memory_write_i) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    is_wr_d = Memory_write_i;
                    misal_d = |address_i[1:0];
                    idx_d   = address_i[DEPTH_LOG2+1:2];
                    wdata_d = write_data_i;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (misal_q) err_d = 1'b1;
                    if (is_wr_q) mem_we = ~misal_q;
                    else         rdata_d = misal_q ? 32'd0 : mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Request is still held by the frozen stage; it is not a new access.
                state_d = IDLE;
                acc_d   = acc_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            misal_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            misal_q <= misal_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

    // Array contents survive reset; an aborted write never reaches mem_we.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end

    assign stall_o      = stall & rst_i;
    assign read_data_o  = rdata_q;
    assign err_o        = err_q;
    assign access_cnt_o = acc_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int LAT = 4;
    localparam int DL2 = 8;
    localparam int NW  = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        stall, err;
    logic [15:0] acc;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_mem [NW];
    logic [31:0] m_rd = '0;
    logic        m_err = 1'b0;
    logic [15:0] m_acc = '0;

    data_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
        .clk_i(clk), .rst_i(rst), .Memory_read_i(rd), .Memory_write_i(wr),
        .address_i(addr), .write_data_i(wdata), .read_data_o(rdata),
        .stall_o(stall), .err_o(err), .access_cnt_o(acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; request presented in cycle t at the preceding negedge.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        int idx;
        bit mis;
        idx = int'((a >> 2) % NW);
        mis = (a % 4) != 0;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        #1 chk("stall_req", 32'(stall), 32'd1);
        repeat (LAT) begin
            @(negedge clk);
            chk("stall_busy", 32'(stall), 32'd1);
        end
        @(negedge clk);
        if (w) begin
            if (!mis) m_mem[idx] = d;
        end else begin
            m_rd = mis ? 32'd0 : m_mem[idx];
        end
        if (mis) m_err = 1'b1;
        chk("stall_done", 32'(stall), 32'd0);
        chk("rdata_done", rdata, m_rd);
        if (!hold) begin rd = 1'b0; wr = 1'b0; end
        @(posedge clk);
        #1;
        if (hold) begin rd = 1'b0; wr = 1'b0; end
        m_acc = m_acc + 16'd1;
        @(negedge clk);
        chk("stall_idle", 32'(stall), 32'd0);
        chk("acc_cnt", 32'(acc), 32'(m_acc));
        chk("err", 32'(err), 32'(m_err));
        chk("rdata_idle", rdata, m_rd);
    endtask

    initial begin
        // Reset state, with a request present: stall must stay low
        rd = 1'b1;
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        rd = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_req", 32'(stall), 32'd0);
        end

        // Write then read 0x10
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("s1_rdata", rdata, 32'hDEADBEEF);
        chk("s1_acc_two", 32'(acc), 32'd2);

        // Fill the whole array so every later read has a known expectation
        for (int i = 0; i < NW; i++)
            access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // Misaligned read
        access(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
        chk("mis_rd_err", 32'(err), 32'd1);
        chk("mis_rd_data", rdata, 32'd0);

        // Misaligned write must not disturb word 0x20
        access(1'b0, 1'b1, 32'h22, 32'h1, 1'b0);
        chk("mis_wr_err", 32'(err), 32'd1);
        access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Simultaneous read+write behaves as a write
        access(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
        access(1'b1, 1'b1, 32'h40, 32'h55, 1'b0);
        access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("rw_mem", rdata, 32'h55);

        // Reset in the second BUSY cycle of a write to 0x8
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = 32'h8; wdata = 32'hAAAA;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_acc", 32'(acc), 32'd0);
        m_rd = '0; m_err = 1'b0; m_acc = '0;
        @(negedge clk); wr = 1'b0;
        @(negedge clk); rst = 1'b1;
        access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

        // Aliasing with the request held through DONE
        access(1'b0, 1'b1, 32'h400, 32'h7, 1'b1);
        access(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("alias_rdata", rdata, 32'h7);
        chk("alias_acc", 32'(acc), 32'd3);
        @(negedge clk);
        chk("alias_idle", 32'(stall), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int op;
            op = int'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            access(op != 1, op != 0, a, $urandom, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
